wb_clint: RTL

WB_CLINT -- requirements
Module: wb_clint

---
 rtl/wb_clint_pkg.sv | 23 ++
 rtl/wb_sel_merge.sv | 19 +
 rtl/wb_clint.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_clint_pkg.sv
// rtl/wb_clint_pkg.sv - shared CLINT offsets, FSM state type and byte-lane mask helper
package WivDefines;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_t;

    // Expand an 8-bit byte-lane select into a 64-bit bit mask
    function automatic logic [63:0] sel_to_mask(input logic [7:0] sel);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_sel_merge.sv
// rtl/wb_sel_merge.sv - byte-lane merge of write data into a current 64-bit value
module wb_sel_merge
    import WivDefines::*;
(
    input  logic [63:0] cur,
    input  logic [63:0] wdat,
    input  logic [7:0]  sel,
    output logic [63:0] merged
);

    logic [63:0] mask;

    // Selected lanes come from the write data, the rest keep the current value
    always_comb begin
        mask   = sel_to_mask(sel);
        merged = (cur & ~mask) | (wdat & mask);
    end

endmodule

// File: rtl/wb_clint.sv
// rtl/wb_clint.sv - Wishbone pipelined CLINT responder for mtime, mtimecmp and msip
module wb_clint
    import WivDefines::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0200_0000,
    parameter logic [15:0] MTIMECMP_OFF = CLINT_MTIMECMP_OFF,
    parameter logic [15:0] MTIME_OFF    = CLINT_MTIME_OFF,
    parameter logic [15:0] MSIP_OFF     = CLINT_MSIP_OFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_wb_adr,
    input  logic [63:0] i_wb_dat,
    output logic [63:0] o_wb_dat,
    input  logic        i_wb_we,
    input  logic [7:0]  i_wb_sel,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    input  logic [63:0] i_mtime,
    input  logic [63:0] i_mtimecmp,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_mtime_we,
    output logic        o_mtimecmp_we,
    output logic        o_msip
);

    clint_state_t state, state_next;

    logic        accept;
    logic        base_hit;
    logic        hit_mtime;
    logic        hit_mtimecmp;
    logic        hit_msip;
    logic        wr_any;
    logic [63:0] rdata;
    logic [63:0] merge_cur;
    logic [63:0] merged;
    logic        pend_mtime_we;
    logic        pend_mtimecmp_we;
    logic        resp_live;
    logic        unused_adr_bits;

    // Byte offset within the doubleword plays no part in decode
    assign unused_adr_bits = ^i_wb_adr[2:0];

    // Accept only in IDLE; stall is exactly "in RESP"
    assign o_wb_stall = (state == RESP);
    assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;

    // Doubleword-granular decode against the 64 KiB window
    always_comb begin
        base_hit     = (i_wb_adr[63:16] == BASE_ADDR[63:16]);
        hit_mtime    = base_hit && (i_wb_adr[15:3] == MTIME_OFF[15:3]);
        hit_mtimecmp = base_hit && (i_wb_adr[15:3] == MTIMECMP_OFF[15:3]);
        hit_msip     = base_hit && (i_wb_adr[15:3] == MSIP_OFF[15:3]);
        wr_any       = i_wb_we && (i_wb_sel != 8'h00);
    end

    // Read mux; unmapped slots read as zero
    always_comb begin
        rdata = '0;
        if (hit_mtime) begin
            rdata = i_mtime;
        end else if (hit_mtimecmp) begin
            rdata = i_mtimecmp;
        end else if (hit_msip) begin
            rdata = {63'b0, o_msip};
        end
    end

    // The current value seen at accept is the base for the byte-lane merge
    assign merge_cur = hit_mtime ? i_mtime : i_mtimecmp;

    wb_sel_merge u_merge (
        .cur    (merge_cur),
        .wdat   (i_wb_dat),
        .sel    (i_wb_sel),
        .merged (merged)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: one request in flight, RESP always lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture read data, merged write values and pending strobes at accept
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_wb_dat         <= '0;
            o_mtime          <= '0;
            o_mtimecmp       <= '0;
            o_msip           <= 1'b0;
            pend_mtime_we    <= 1'b0;
            pend_mtimecmp_we <= 1'b0;
        end else begin
            pend_mtime_we    <= accept && wr_any && hit_mtime;
            pend_mtimecmp_we <= accept && wr_any && hit_mtimecmp;
            if (accept) begin
                if (!i_wb_we) begin
                    o_wb_dat <= rdata;
                end
                if (wr_any && hit_mtime) begin
                    o_mtime <= merged;
                end
                if (wr_any && hit_mtimecmp) begin
                    o_mtimecmp <= merged;
                end
                if (i_wb_we && hit_msip && i_wb_sel[0]) begin
                    o_msip <= i_wb_dat[0];
                end
            end
        end
    end

    // Ack and load strobes are gated live so an abort or reset in RESP kills them
    assign resp_live     = (state == RESP) && i_wb_cyc && i_reset;
    assign o_wb_ack      = resp_live;
    assign o_mtime_we    = resp_live && pend_mtime_we;
    assign o_mtimecmp_we = resp_live && pend_mtimecmp_we;

endmodule
